// File: rtl/ppt_sequencer.sv
// Burst pulse generator for the pulsed plasma thruster firing pad.
// Inputs are captured only in IDLE; a prescaler divides clk_i into ticks that time the pulses.
module ppt_sequencer #(
    parameter int PRE_W = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  clk_div_i,
    input  logic [15:0] period_i,
    input  logic [15:0] width_i,
    input  logic [15:0] count_i,
    input  logic        run_ppt_i,
    output logic        ppt_pulse_o,
    output logic [15:0] count_done_o,
    output logic        done_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_START  = 2'd1,
        S_FIRING = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  clk_div_l_q, clk_div_l_d;
    logic [15:0] period_l_q, period_l_d;
    logic [15:0] width_l_q, width_l_d;
    logic [15:0] count_l_q, count_l_d;
    logic [PRE_W-1:0] prescaler_q, prescaler_d;
    logic [15:0] tick_cnt_q, tick_cnt_d;
    logic [15:0] count_done_q, count_done_d;
    logic        done_q, done_d;
    logic        pulse_q, pulse_d;

    logic [PRE_W-1:0] pre_max;
    logic [15:0]      per_eff;
    logic [15:0]      count_done_inc;
    logic             tick;
    logic             per_last;

    // With PRE_W = 32 and clk_div = 31 the shift yields 0, so pre_max becomes all ones.
    assign pre_max        = (PRE_W'(1) << ({1'b0, clk_div_l_q} + 6'd1)) - PRE_W'(1);
    assign tick           = (prescaler_q == pre_max);
    assign per_eff        = (period_l_q == 16'd0) ? 16'd1 : period_l_q;
    assign per_last       = (tick_cnt_q == per_eff - 16'd1);
    assign count_done_inc = count_done_q + 16'd1;

    always_comb begin
        state_d      = state_q;
        clk_div_l_d  = clk_div_l_q;
        period_l_d   = period_l_q;
        width_l_d    = width_l_q;
        count_l_d    = count_l_q;
        prescaler_d  = prescaler_q;
        tick_cnt_d   = tick_cnt_q;
        count_done_d = count_done_q;
        done_d       = done_q;
        pulse_d      = pulse_q;

        case (state_q)
            S_IDLE: begin
                clk_div_l_d = clk_div_i;
                period_l_d  = period_i;
                width_l_d   = width_i;
                count_l_d   = count_i;
                pulse_d     = 1'b0;
                if (run_ppt_i) state_d = S_START;
            end
            S_START: begin
                if (!run_ppt_i) begin
                    pulse_d = 1'b0;
                    state_d = S_IDLE;
                end else if (count_l_q == 16'd0) begin
                    done_d       = 1'b1;
                    count_done_d = 16'd0;
                    pulse_d      = 1'b0;
                    state_d      = S_DONE;
                end else begin
                    prescaler_d  = '0;
                    tick_cnt_d   = 16'd0;
                    count_done_d = 16'd0;
                    done_d       = 1'b0;
                    pulse_d      = (width_l_q != 16'd0);
                    state_d      = S_FIRING;
                end
            end
            S_FIRING: begin
                if (!run_ppt_i) begin
                    pulse_d = 1'b0;
                    state_d = S_IDLE;
                end else if (tick) begin
                    prescaler_d = '0;
                    if (per_last) begin
                        tick_cnt_d   = 16'd0;
                        count_done_d = count_done_inc;
                        if (count_done_inc == count_l_q) begin
                            pulse_d = 1'b0;
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            pulse_d = (width_l_q != 16'd0);
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 16'd1;
                        // 17-bit compare so tick_cnt = 0xFFFF cannot wrap to a false "below width".
                        pulse_d    = (({1'b0, tick_cnt_q} + 17'd1) < {1'b0, width_l_q});
                    end
                end else begin
                    prescaler_d = prescaler_q + PRE_W'(1);
                end
            end
            S_DONE: begin
                pulse_d = 1'b0;
                if (!run_ppt_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            clk_div_l_q  <= 5'd0;
            period_l_q   <= 16'd0;
            width_l_q    <= 16'd0;
            count_l_q    <= 16'd0;
            prescaler_q  <= '0;
            tick_cnt_q   <= 16'd0;
            count_done_q <= 16'd0;
            done_q       <= 1'b0;
            pulse_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            clk_div_l_q  <= clk_div_l_d;
            period_l_q   <= period_l_d;
            width_l_q    <= width_l_d;
            count_l_q    <= count_l_d;
            prescaler_q  <= prescaler_d;
            tick_cnt_q   <= tick_cnt_d;
            count_done_q <= count_done_d;
            done_q       <= done_d;
            pulse_q      <= pulse_d;
        end
    end

    assign ppt_pulse_o  = pulse_q;
    assign count_done_o = count_done_q;
    assign done_o       = done_q;
    assign busy_o       = (state_q == S_FIRING);

endmodule

// File: tb/tb_ppt_sequencer.sv
// Directed bench for ppt_sequencer: bursts are checked cycle by cycle against
// a closed-form pulse/count model derived from the timing rules.
module tb_ppt_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [4:0]  clk_div_i = 5'd0;
    logic [15:0] period_i = 16'd0;
    logic [15:0] width_i = 16'd0;
    logic [15:0] count_i = 16'd0;
    logic        run_ppt_i = 1'b0;
    logic        ppt_pulse_o;
    logic [15:0] count_done_o;
    logic        done_o;
    logic        busy_o;

    int n_tot = 0;
    int n_bad = 0;

    ppt_sequencer dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clk_div_i    (clk_div_i),
        .period_i     (period_i),
        .width_i      (width_i),
        .count_i      (count_i),
        .run_ppt_i    (run_ppt_i),
        .ppt_pulse_o  (ppt_pulse_o),
        .count_done_o (count_done_o),
        .done_o       (done_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_cfg(input int cd, input int per, input int w, input int cnt);
        clk_div_i = cd[4:0];
        period_i  = per[15:0];
        width_i   = w[15:0];
        count_i   = cnt[15:0];
    endtask

    // Next posedge is the one where IDLE sees run high (i = 0); check through i = last.
    // last < 0 means the whole burst plus two cycles of DONE.
    task automatic watch(input string nm, input int cd, input int per, input int w, input int cnt,
                         input int last, input int chg_at, input int chg_w);
        int t, pe, flen, total, lim, k, p;
        logic exp_pulse, exp_done, exp_busy;
        int exp_cd;
        t     = 1 << (cd + 1);
        pe    = (per == 0) ? 1 : per;
        flen  = t * pe;
        total = cnt * flen;
        lim   = (last < 0) ? total + 2 : last;
        for (int i = 0; i <= lim; i++) begin
            @(posedge clk_i);
            #1;
            if (i == chg_at) width_i = chg_w[15:0];
            if (i == 0) begin
                chk($sformatf("%s pulse@%0d", nm, i), ppt_pulse_o, 0);
                chk($sformatf("%s busy@%0d", nm, i), busy_o, 0);
            end else begin
                k = i - 1;
                if (k < total) begin
                    p         = k % flen;
                    exp_pulse = ((p / t) < w);
                    exp_cd    = k / flen;
                    exp_done  = 1'b0;
                    exp_busy  = 1'b1;
                end else begin
                    exp_pulse = 1'b0;
                    exp_cd    = cnt;
                    exp_done  = 1'b1;
                    exp_busy  = 1'b0;
                end
                chk($sformatf("%s pulse@%0d", nm, i), ppt_pulse_o, exp_pulse);
                chk($sformatf("%s cd@%0d", nm, i), count_done_o, exp_cd);
                chk($sformatf("%s done@%0d", nm, i), done_o, exp_done);
                chk($sformatf("%s busy@%0d", nm, i), busy_o, exp_busy);
            end
        end
    endtask

    task automatic idle_gap(input string nm, input logic [15:0] cd_hold, input logic done_hold);
        run_ppt_i = 1'b0;
        @(posedge clk_i);
        #1;
        chk({nm, " gap pulse"}, ppt_pulse_o, 0);
        chk({nm, " gap busy"}, busy_o, 0);
        chk({nm, " gap cd"}, count_done_o, cd_hold);
        chk({nm, " gap done"}, done_o, done_hold);
    endtask

    initial begin
        // Reset held with run high: outputs at reset values.
        set_cfg(0, 4, 1, 2);
        run_ppt_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("rst pulse", ppt_pulse_o, 0);
        chk("rst cd", count_done_o, 0);
        chk("rst done", done_o, 0);
        chk("rst busy", busy_o, 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // 1: 2-high / 8-cycle firings, two firings.
        watch("t1", 0, 4, 1, 2, -1, -1, 0);
        idle_gap("t1", 16'd2, 1'b1);

        // 2: zero count goes straight to done.
        set_cfg(0, 4, 1, 0);
        run_ppt_i = 1'b1;
        watch("t2", 0, 4, 1, 0, -1, -1, 0);
        idle_gap("t2", 16'd0, 1'b1);

        // 3: width >= period gives one continuous 12-cycle pulse.
        set_cfg(0, 3, 5, 2);
        run_ppt_i = 1'b1;
        watch("t3", 0, 3, 5, 2, -1, -1, 0);
        idle_gap("t3", 16'd2, 1'b1);

        // Period 0 behaves as period 1.
        set_cfg(0, 0, 2, 3);
        run_ppt_i = 1'b1;
        watch("p0", 0, 0, 2, 3, -1, -1, 0);
        idle_gap("p0", 16'd3, 1'b1);

        // 4: abort after the 2nd firing, then restart from zero.
        set_cfg(0, 4, 1, 5);
        run_ppt_i = 1'b1;
        watch("t4", 0, 4, 1, 5, 17, -1, 0);
        idle_gap("t4a", 16'd2, 1'b0);
        run_ppt_i = 1'b1;
        watch("t4r", 0, 4, 1, 5, -1, -1, 0);
        idle_gap("t4r", 16'd5, 1'b1);

        // 5: width changed mid-burst is ignored until the next burst.
        set_cfg(1, 4, 1, 3);
        run_ppt_i = 1'b1;
        watch("t5", 1, 4, 1, 3, -1, 5, 3);
        idle_gap("t5", 16'd3, 1'b1);
        clk_div_i = 5'd0;
        count_i   = 16'd2;
        run_ppt_i = 1'b1;
        watch("t5n", 0, 4, 3, 2, -1, -1, 0);
        idle_gap("t5n", 16'd2, 1'b1);

        // 6: asynchronous reset while the pulse is high.
        set_cfg(0, 4, 3, 4);
        run_ppt_i = 1'b1;
        watch("t6", 0, 4, 3, 4, 9, -1, 0);
        #3;
        rst_i = 1'b1;
        #1;
        chk("t6 async pulse", ppt_pulse_o, 0);
        chk("t6 async cd", count_done_o, 0);
        chk("t6 async done", done_o, 0);
        chk("t6 async busy", busy_o, 0);
        run_ppt_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
